// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a word bus with byte lanes,
// stalls the pipeline per access, extends loads, flags faults.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_M,
    input  logic [31:0] wd_M,
    input  logic [1:0]  store_sel_M,
    input  logic [2:0]  load_sel_M,
    input  logic        write_enable_dmem_M,
    input  logic        load_en_M,
    output logic        stall_M,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data_M,
    output logic        mem_done,
    output logic        exc_misaligned,
    output logic        exc_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off_q;
    logic [2:0]  lsel_q;

    logic        access;
    logic        mis_store;
    logic        mis_load;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign access     = write_enable_dmem_M | load_en_M;
    assign misaligned = write_enable_dmem_M ? mis_store : mis_load;
    assign stall_M    = (state == IDLE && access) || state == REQ;

    always_comb begin
        mis_store = 1'b1;
        case (store_sel_M)
            2'b00:   mis_store = |addr_M[1:0];
            2'b01:   mis_store = addr_M[0];
            2'b10:   mis_store = 1'b0;
            default: mis_store = 1'b1;
        endcase
    end

    always_comb begin
        mis_load = |addr_M[1:0];
        case (load_sel_M)
            3'b001, 3'b010: mis_load = addr_M[0];
            3'b011, 3'b100: mis_load = 1'b0;
            default:        mis_load = |addr_M[1:0];
        endcase
    end

    always_comb begin
        st_wdata = wd_M;
        st_be    = 4'b1111;
        case (store_sel_M)
            2'b01: begin
                st_wdata = {2{wd_M[15:0]}};
                st_be    = addr_M[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_wdata = {4{wd_M[7:0]}};
                st_be    = 4'b0001 << addr_M[1:0];
            end
            default: ;
        endcase
    end

    // Lane select uses the address captured at issue, not the live M input.
    assign rd_shift = bus_rdata >> {off_q, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        ld_ext = bus_rdata;
        unique case (1'b1)
            lsel_q == 3'b001: ld_ext = {{16{rd_half[15]}}, rd_half};
            lsel_q == 3'b010: ld_ext = {16'h0000, rd_half};
            lsel_q == 3'b011: ld_ext = {{24{rd_byte[7]}}, rd_byte};
            lsel_q == 3'b100: ld_ext = {24'h000000, rd_byte};
            default:          ld_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            off_q          <= 2'b00;
            lsel_q         <= 3'b000;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'd0;
            bus_wdata      <= 32'd0;
            bus_be         <= 4'b0000;
            load_data_M    <= 32'd0;
            mem_done       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;
        end else begin
            mem_done       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        state          <= ERR;
                        exc_misaligned <= 1'b1;
                    end else if (access) begin
                        state     <= REQ;
                        cnt       <= 8'd0;
                        bus_req   <= 1'b1;
                        bus_we    <= write_enable_dmem_M;
                        bus_addr  <= {addr_M[31:2], 2'b00};
                        bus_wdata <= write_enable_dmem_M ? st_wdata : wd_M;
                        bus_be    <= write_enable_dmem_M ? st_be : 4'b1111;
                        off_q     <= addr_M[1:0];
                        lsel_q    <= load_sel_M;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        mem_done <= 1'b1;
                        if (!bus_we)
                            load_data_M <= ld_ext;
                    end else if (cnt == CNT_MAX) begin
                        state       <= ERR;
                        bus_req     <= 1'b0;
                        exc_bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a per-instruction
// cycle-trace model, plus directed literal cases.
module tb_mem_stage_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_M, wd_M;
    logic [1:0]  store_sel_M;
    logic [2:0]  load_sel_M;
    logic        write_enable_dmem_M, load_en_M;
    logic        stall_M, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata, load_data_M;
    logic        mem_done, exc_misaligned, exc_bus_err;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .addr_M(addr_M), .wd_M(wd_M),
        .store_sel_M(store_sel_M), .load_sel_M(load_sel_M),
        .write_enable_dmem_M(write_enable_dmem_M), .load_en_M(load_en_M),
        .stall_M(stall_M), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .load_data_M(load_data_M), .mem_done(mem_done),
        .exc_misaligned(exc_misaligned), .exc_bus_err(exc_bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic        ex_valid = 1'b0;
    logic        e_stall, e_req, e_done, e_mis, e_berr, e_bus, e_we, e_wdchk;
    logic [31:0] e_addr, e_wd, model_ld;
    logic [3:0]  e_be;

    int stall_cnt, req_cnt, done_cnt, mis_cnt, berr_cnt, req_rise;
    logic req_prev = 1'b0;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ex_valid) begin
            chk("stall_M", stall_M, e_stall);
            chk("bus_req", bus_req, e_req);
            chk("mem_done", mem_done, e_done);
            chk("exc_misaligned", exc_misaligned, e_mis);
            chk("exc_bus_err", exc_bus_err, e_berr);
            chk("load_data_M", load_data_M, model_ld);
            if (e_bus) begin
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_we", bus_we, e_we);
                chk("bus_be", bus_be, e_be);
                if (e_wdchk) chk("bus_wdata", bus_wdata, e_wd);
            end
        end
        stall_cnt += int'(stall_M);
        req_cnt   += int'(bus_req);
        done_cnt  += int'(mem_done);
        mis_cnt   += int'(exc_misaligned);
        berr_cnt  += int'(exc_bus_err);
        if (bus_req && !req_prev) req_rise++;
        req_prev = bus_req;
    end

    task automatic clr_cnt();
        stall_cnt = 0; req_cnt = 0; done_cnt = 0;
        mis_cnt = 0; berr_cnt = 0; req_rise = 0;
    endtask

    task automatic set_exp(input logic s, r, d, m, b, bus);
        e_stall = s; e_req = r; e_done = d; e_mis = m; e_berr = b; e_bus = bus;
    endtask

    function automatic logic mis_st(input logic [1:0] ss, input logic [31:0] a);
        case (ss)
            2'd0:    return (a % 4) != 0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic mis_ld(input logic [2:0] ls, input logic [31:0] a);
        case (ls)
            3'd1, 3'd2: return (a % 2) != 0;
            3'd3, 3'd4: return 1'b0;
            default:    return (a % 4) != 0;
        endcase
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] ls);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) & 32'hff;
        h = (rd >> (16 * (off / 2))) & 32'hffff;
        case (ls)
            3'd1:    return h[15] ? (h | 32'hffff0000) : h;
            3'd2:    return h;
            3'd3:    return b[7] ? (b | 32'hffffff00) : b;
            3'd4:    return b;
            default: return rd;
        endcase
    endfunction

    // w = REQ cycle index carrying bus_ready; w >= T means the bus never answers.
    task automatic run_instr(input logic we, ld, input logic [1:0] ss, input logic [2:0] ls,
                             input logic [31:0] a, d, input int w, input logic [31:0] rd);
        logic mis;
        mis = we ? mis_st(ss, a) : mis_ld(ls, a);
        e_we = we; e_wdchk = we; e_addr = {a[31:2], 2'b00};
        e_be = 4'hf; e_wd = d;
        if (we && ss == 2'd1) begin
            e_wd = {d[15:0], d[15:0]}; e_be = a[1] ? 4'b1100 : 4'b0011;
        end else if (we && ss == 2'd2) begin
            e_wd = {4{d[7:0]}}; e_be = 4'(1 << a[1:0]);
        end
        write_enable_dmem_M = we; load_en_M = ld; store_sel_M = ss;
        load_sel_M = ls; addr_M = a; wd_M = d;
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        set_exp(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        if (mis) begin
            set_exp(0, 0, 0, 1, 0, 0);
            bus_ready = 1'($urandom);
        end else begin
            for (int j = 0; j < T; j++) begin
                bus_ready = (j == w);
                bus_rdata = (j == w) ? rd : $urandom;
                set_exp(1, 1, 0, 0, 0, 1);
                if (j == 0) begin
                    cap_addr = bus_addr; cap_wd = bus_wdata;
                    cap_be = bus_be; cap_we = bus_we;
                end
                @(posedge clk); #1;
                if (j == w) break;
            end
            if (w < T) begin
                if (!we) model_ld = ext_load(rd, a[1:0], ls);
                set_exp(0, 0, 1, 0, 0, 0);
            end else begin
                set_exp(0, 0, 0, 0, 1, 0);
            end
            bus_ready = 1'($urandom);
        end
        @(posedge clk); #1;
        write_enable_dmem_M = 0; load_en_M = 0; bus_ready = 0;
        set_exp(0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_cycle();
        write_enable_dmem_M = 0; load_en_M = 0;
        addr_M = $urandom; wd_M = $urandom;
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        set_exp(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; addr_M = 0; wd_M = 0; store_sel_M = 0; load_sel_M = 0;
        write_enable_dmem_M = 0; load_en_M = 0; bus_ready = 0; bus_rdata = 0;
        model_ld = 0; clr_cnt();
        #3;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_load_data", load_data_M, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_stall", stall_M, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        set_exp(0, 0, 0, 0, 0, 0);
        ex_valid = 1;
        @(posedge clk); #1;

        clr_cnt();
        run_instr(0, 1, 0, 3'd3, 32'h103, 0, 0, 32'h80AA_BBCC);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_data", load_data_M, 32'hFFFF_FF80);
        chk("lb_stall", stall_cnt, 2);
        chk("lb_done", done_cnt, 1);
        clr_cnt();
        run_instr(0, 1, 0, 3'd4, 32'h103, 0, 0, 32'h80AA_BBCC);
        chk("lbu_data", load_data_M, 32'h0000_0080);

        clr_cnt();
        run_instr(1, 0, 2'd1, 0, 32'h206, 32'h1234_5678, 3, 32'hDEAD_BEEF);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wd, 32'h5678_5678);
        chk("sh_we", cap_we, 1);
        chk("sh_stall", stall_cnt, 5);
        chk("sh_ld_hold", load_data_M, 32'h0000_0080);

        clr_cnt();
        run_instr(0, 1, 0, 3'd0, 32'h102, 0, 0, 0);
        chk("mis_lw_stall", stall_cnt, 1);
        chk("mis_lw_exc", mis_cnt, 1);
        chk("mis_lw_req", req_cnt, 0);
        clr_cnt();
        run_instr(1, 0, 2'd1, 0, 32'h001, 32'h55, 0, 0);
        chk("mis_sh_stall", stall_cnt, 1);
        chk("mis_sh_exc", mis_cnt, 1);
        chk("mis_sh_req", req_cnt, 0);

        clr_cnt();
        run_instr(0, 1, 0, 3'd0, 32'h40, 0, T, 0);
        chk("to_req_cycles", req_cnt, T);
        chk("to_berr", berr_cnt, 1);
        chk("to_done", done_cnt, 0);
        clr_cnt();
        run_instr(0, 1, 0, 3'd0, 32'h44, 0, T - 1, 32'h0BAD_F00D);
        chk("late_berr", berr_cnt, 0);
        chk("late_done", done_cnt, 1);
        chk("late_data", load_data_M, 32'h0BAD_F00D);

        clr_cnt();
        run_instr(1, 0, 2'd0, 0, 32'h10, 32'hCAFE_0001, 1, 0);
        run_instr(0, 1, 0, 3'd1, 32'h12, 0, 0, 32'h8001_1234);
        chk("b2b_txns", req_rise, 2);
        chk("b2b_data", load_data_M, 32'hFFFF_8001);

        ex_valid = 0;
        write_enable_dmem_M = 0; load_en_M = 1; load_sel_M = 0; addr_M = 32'h80;
        @(posedge clk); #1;
        chk("pre_rst_req", bus_req, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_data", load_data_M, 0);
        chk("mid_rst_addr", bus_addr, 0);
        load_en_M = 0;
        #1 chk("mid_rst_stall", stall_M, 0);
        @(posedge clk); #3 rst_n = 1;
        model_ld = 0;
        @(posedge clk); #1;
        set_exp(0, 0, 0, 0, 0, 0);
        ex_valid = 1;

        for (int i = 0; i < 300; i++) begin
            int k, w, nidle;
            logic we, ld;
            nidle = $urandom_range(0, 2);
            for (int n = 0; n < nidle; n++) idle_cycle();
            k = $urandom_range(0, 8);
            we = (k <= 3) || (k == 8);
            ld = (k >= 4);
            w = ($urandom_range(0, 4) == 0) ? T : $urandom_range(0, T - 1);
            run_instr(we, ld, 2'($urandom), 3'($urandom),
                      {$urandom} & 32'hFFFF_FFFF, $urandom, w, $urandom);
        end

        ex_valid = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
